// File: rtl/vga_scan_ctrl.sv
// VGA scan master: pixel divider, h/v counters, scan coordinates,
// sync/blank alignment to the colour pipeline and RGB444 output.
module vga_scan_ctrl #(
  parameter int PIX_DIV = 4,
  parameter int H_ACT   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_ACT   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int PIPE    = 1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [15:0] color_in,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        active,
  output logic        pix_tick,
  output logic        frame_tick,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int DW    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] H_A    = 10'(H_ACT);
  localparam logic [9:0] V_A    = 10'(V_ACT);
  localparam logic [9:0] V_PRE  = 10'(V_ACT - 1);
  localparam logic [9:0] HS_B   = 10'(H_ACT + H_FP);
  localparam logic [9:0] HS_E   = 10'(H_ACT + H_FP + H_SYNC);
  localparam logic [9:0] VS_B   = 10'(V_ACT + V_FP);
  localparam logic [9:0] VS_E   = 10'(V_ACT + V_FP + V_SYNC);

  logic [DW-1:0]     div_cnt;
  logic              run;
  logic [9:0]        h_cnt;
  logic [9:0]        v_cnt;
  logic              h_last;
  logic              hs_raw;
  logic              vs_raw;
  logic              act_raw;
  logic [2:0]        dly_in;
  logic [3*PIPE-1:0] dly;
  logic [3*PIPE-1:0] dly_nxt;
  logic              cap_act;
  logic              unused_bits;

  // run keeps the first tick PIX_DIV clocks after reset release,
  // including the PIX_DIV=1 case where the divider is constant.
  assign pix_tick = run && (div_cnt == DIV_LAST);
  assign h_last   = (h_cnt == H_LAST);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      div_cnt <= '0;
      run     <= 1'b0;
    end else begin
      run <= 1'b1;
      if (div_cnt == DIV_LAST)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pix_tick && h_last && (v_cnt == V_PRE);
      if (pix_tick) begin
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  assign hs_raw  = !((h_cnt >= HS_B) && (h_cnt < HS_E));
  assign vs_raw  = !((v_cnt >= VS_B) && (v_cnt < VS_E));
  assign act_raw = (h_cnt < H_A) && (v_cnt < V_A);
  assign dly_in  = {hs_raw, vs_raw, act_raw};

  generate
    if (PIPE == 1) begin : g_one
      assign dly_nxt = dly_in;
    end else begin : g_shift
      assign dly_nxt = {dly[3*PIPE-4:0], dly_in};
    end
  endgenerate

  // Gate colour with the active bit entering the last stage so the
  // captured RGB lines up with the hs/vs leaving the delay line.
  assign cap_act = dly_nxt[3*PIPE-3];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      dly       <= {PIPE{3'b110}};
      {r, g, b} <= 12'h000;
    end else if (pix_tick) begin
      dly       <= dly_nxt;
      {r, g, b} <= cap_act ? color_in[11:0] : 12'h000;
    end
  end

  assign hs     = dly[3*PIPE-1];
  assign vs     = dly[3*PIPE-2];
  assign x      = h_cnt;
  assign y      = v_cnt[8:0];
  assign active = act_raw;

  assign unused_bits = ^{color_in[15:12], dly[3*PIPE-3]};

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl using a shrunken 16x11 raster so
// full frames fit; two instances cover PIPE=1/DIV=4 and PIPE=3/DIV=1.
module tb_vga_scan_ctrl;

  logic        clk;
  logic        clrn;
  logic        mode1;
  logic [15:0] c1, c3;
  logic [9:0]  x1, x3;
  logic [8:0]  y1, y3;
  logic        a1, a3, pt1, pt3, ft1, ft3;
  logic        hs1, hs3, vs1, vs3;
  logic [3:0]  r1, g1, b1, r3, g3, b3;

  int n_chk = 0;
  int n_err = 0;

  int n, line_ticks, hs_first, hs_len, vs_len, ymax;
  int ft1_cnt, ft_x, ft_y, abc_cnt, abc_x, abc_y;
  int blank_bad, fff_cnt, hs3_first, hs3_len;
  int abc3_cnt, abc3_x, abc3_y, ft1_first, ft3_first, found;
  logic        prev_act;
  logic [11:0] exp_rgb;

  vga_scan_ctrl #(
    .PIX_DIV(4), .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACT(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .PIPE(1)
  ) dut1 (
    .clk(clk), .clrn(clrn), .color_in(c1),
    .x(x1), .y(y1), .active(a1), .pix_tick(pt1),
    .frame_tick(ft1), .hs(hs1), .vs(vs1),
    .r(r1), .g(g1), .b(b1)
  );

  vga_scan_ctrl #(
    .PIX_DIV(1), .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACT(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .PIPE(3)
  ) dut3 (
    .clk(clk), .clrn(clrn), .color_in(c3),
    .x(x3), .y(y3), .active(a3), .pix_tick(pt3),
    .frame_tick(ft3), .hs(hs3), .vs(vs3),
    .r(r3), .g(g3), .b(b3)
  );

  // Sprite stand-ins: dut1 colour for (3,2) arrives during that
  // coordinate; dut3 colour for (3,2) arrives two ticks later.
  assign c1 = mode1 ? 16'hFFFF :
              ((x1 == 10'd3 && y1 == 9'd2) ? 16'h0ABC : 16'hF000);
  assign c3 = (x3 == 10'd5 && y3 == 9'd2) ? 16'h0ABC : 16'hF000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_x1"}, 32'(x1), 0);
    chk({tag, "_y1"}, 32'(y1), 0);
    chk({tag, "_act1"}, 32'(a1), 1);
    chk({tag, "_pt1"}, 32'(pt1), 0);
    chk({tag, "_ft1"}, 32'(ft1), 0);
    chk({tag, "_hs1"}, 32'(hs1), 1);
    chk({tag, "_vs1"}, 32'(vs1), 1);
    chk({tag, "_rgb1"}, 32'({r1, g1, b1}), 0);
    chk({tag, "_x3"}, 32'(x3), 0);
    chk({tag, "_y3"}, 32'(y3), 0);
    chk({tag, "_pt3"}, 32'(pt3), 0);
    chk({tag, "_hs3"}, 32'(hs3), 1);
    chk({tag, "_vs3"}, 32'(vs3), 1);
    chk({tag, "_rgb3"}, 32'({r3, g3, b3}), 0);
  endtask

  initial begin
    mode1 = 1'b0;
    clrn = 1'b1;
    #1 clrn = 1'b0;
    line_ticks = 0; hs_first = -1; hs_len = 0; vs_len = 0; ymax = 0;
    ft1_cnt = 0; ft_x = -1; ft_y = -1;
    abc_cnt = 0; abc_x = -1; abc_y = -1;
    blank_bad = 0; fff_cnt = 0; hs3_first = -1; hs3_len = 0;
    abc3_cnt = 0; abc3_x = -1; abc3_y = -1;
    ft1_first = 0; ft3_first = 0; found = 0;
    prev_act = 1'b0;

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    clrn = 1'b1;

    for (int k = 1; k <= 1412; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k <= 12) chk("pix_tick_div4", 32'(pt1), 32'(k % 4 == 3));
      if (k == 1) chk("pix_tick_div1", 32'(pt3), 1);
      if (ft1 && k <= 707) begin
        ft1_cnt++;
        ft_x = int'(x1);
        ft_y = int'(y1);
      end
      if (ft3 && ft3_first == 0) ft3_first = k;
      if (pt1) begin
        n = (k - 3) / 4;
        if (n < 176) begin
          if (y1 == 9'd0) line_ticks++;
          if (y1 == 9'd0 && !hs1) begin
            if (hs_len == 0) hs_first = int'(x1);
            hs_len++;
          end
          if (!vs1) vs_len++;
          if (int'(y1) > ymax) ymax = int'(y1);
          if ({r1, g1, b1} == 12'hABC) begin
            abc_cnt++;
            abc_x = int'(x1);
            abc_y = int'(y1);
          end
          if (n == 16) begin
            chk("line_wrap_x", 32'(x1), 0);
            chk("line_wrap_y", 32'(y1), 1);
          end
          if (n == 175) mode1 = 1'b1;
        end
        if (n == 176) begin
          chk("frame_wrap_x", 32'(x1), 0);
          chk("frame_wrap_y", 32'(y1), 0);
        end
        if (n >= 177) begin
          exp_rgb = prev_act ? 12'hFFF : 12'h000;
          if ({r1, g1, b1} !== exp_rgb) blank_bad++;
          if ({r1, g1, b1} == 12'hFFF) fff_cnt++;
        end
        prev_act = (x1 < 10'd8) && (y1 < 9'd6);
      end
      if (k <= 176) begin
        if (y3 == 9'd0 && !hs3) begin
          if (hs3_len == 0) hs3_first = int'(x3);
          hs3_len++;
        end
        if ({r3, g3, b3} == 12'hABC) begin
          abc3_cnt++;
          abc3_x = int'(x3);
          abc3_y = int'(y3);
        end
      end
    end

    chk("line_ticks", 32'(line_ticks), 16);
    chk("hs_start_x", 32'(hs_first), 11);
    chk("hs_width", 32'(hs_len), 3);
    chk("vs_width", 32'(vs_len), 32);
    chk("y_max", 32'(ymax), 10);
    chk("frame_tick_count", 32'(ft1_cnt), 1);
    chk("frame_tick_x", 32'(ft_x), 0);
    chk("frame_tick_y", 32'(ft_y), 6);
    chk("colour_p1_count", 32'(abc_cnt), 1);
    chk("colour_p1_x", 32'(abc_x), 4);
    chk("colour_p1_y", 32'(abc_y), 2);
    chk("blank_bad", 32'(blank_bad), 0);
    chk("blank_fff", 32'(fff_cnt), 48);
    chk("hs3_start_x", 32'(hs3_first), 13);
    chk("hs3_width", 32'(hs3_len), 3);
    chk("colour_p3_count", 32'(abc3_cnt), 1);
    chk("colour_p3_x", 32'(abc3_x), 6);
    chk("colour_p3_y", 32'(abc3_y), 2);
    chk("frame_tick3_first", 32'(ft3_first), 97);

    for (int i = 0; i < 800 && found == 0; i++) begin
      @(negedge clk);
      if (x1 == 10'd5 && y1 == 9'd3) found = 1;
    end
    chk("mid_point_found", 32'(found), 1);
    #2 clrn = 1'b0;
    #1 chk_reset("mid_reset");
    repeat (3) @(negedge clk);
    clrn = 1'b1;

    ft1_first = 0;
    ft3_first = 0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 3) begin
        chk("restart_x", 32'(x1), 0);
        chk("restart_y", 32'(y1), 0);
      end
      if (k == 4) chk("restart_x_step", 32'(x1), 1);
      if (ft1 && ft1_first == 0) ft1_first = k;
      if (ft3 && ft3_first == 0) ft3_first = k;
    end
    chk("restart_frame_tick1", 32'(ft1_first), 384);
    chk("restart_frame_tick3", 32'(ft3_first), 97);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- Scan-side master of the pixel interface that all sprite/colour-choice blocks use.
- Generates the pixel tick, horizontal and vertical counters, and the scan coordinates x/y that are broadcast to the sprite blocks.
- Samples the merged 16-bit colour those blocks return, re-aligns sync and blanking to the colour pipeline latency, and drives the VGA pins.
- Also emits a per-frame tick that game logic uses to update sprite positions.

Parameters:
- PIX_DIV, 4, system clocks per pixel tick (100 MHz -> 25 MHz); legal values are 1 or more.
- H_ACT, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACT, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- PIPE, 1, colour return latency in pixel ticks; legal range is 1 to 4.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- clrn  in  1  asynchronous active-low reset.
- color_in  in  16  merged sprite colour for the coordinates issued PIPE ticks earlier; bits [11:0] are RGB444 {R,G,B}, bits [15:12] are ignored.
- x  out  10  horizontal scan coordinate (h_cnt).
- y  out  9  vertical scan coordinate (v_cnt[8:0]).
- active  out  1  high while h_cnt < H_ACT and v_cnt < V_ACT; undelayed, aligned with x/y.
- pix_tick  out  1  one-clk strobe on which the counters advance.
- frame_tick  out  1  one-clk pulse when the counters enter h_cnt=0, v_cnt=V_ACT (start of vertical blanking).
- hs  out  1  horizontal sync, active low, delayed by PIPE ticks.
- vs  out  1  vertical sync, active low, delayed by PIPE ticks.
- r  out  4  red output.
- g  out  4  green output.
- b  out  4  blue output.

Behaviour:
- Divider: div_cnt counts 0 to PIX_DIV-1 and wraps. pix_tick=1 during the clk cycle in which div_cnt == PIX_DIV-1. With PIX_DIV=1, pix_tick is held at 1.
- Horizontal counter: h_cnt (10 bits) advances only on pix_tick. H_TOT = H_ACT+H_FP+H_SYNC+H_BP (800). h_cnt wraps from H_TOT-1 to 0.
- Vertical counter: v_cnt (10 bits) increments when h_cnt wraps. V_TOT = 525. v_cnt wraps from V_TOT-1 to 0.
- Raw sync: hs_raw=0 when H_ACT+H_FP <= h_cnt < H_ACT+H_FP+H_SYNC (656..751). vs_raw=0 when V_ACT+V_FP <= v_cnt < V_ACT+V_FP+V_SYNC (490..491).
- Coordinate outputs: x = h_cnt. y = v_cnt[8:0]. During blanking, y aliases for v_cnt >= 512; this is harmless because blanking forces black.
- Delay line: a PIPE-deep shift register of {hs_raw, vs_raw, active}, advanced on pix_tick.
- Colour capture: on each pix_tick, if the delayed active is 1, {r,g,b} <= color_in[11:0]; otherwise {r,g,b} <= 0. hs and vs are the delayed values, so sync, blank and colour stay mutually aligned.
- RGB, hs and vs change only on pix_tick edges and hold between ticks.
- frame_tick: registered, high for exactly one clk, on the same edge that makes v_cnt=V_ACT with h_cnt=0.
- Reset (clrn=0, async, at any time including mid-line):
  - div_cnt, h_cnt, v_cnt and the delay line are cleared to 0, with the stored sync bits set to 1.
  - Outputs: x=0, y=0, active=1 (counters at 0,0), pix_tick=0, frame_tick=0, hs=1, vs=1, r=g=b=0.
- After reset release: the first pix_tick occurs PIX_DIV clks later. The first frame_tick occurs 480*800 ticks after release.
- color_in is only sampled on pix_tick; changes between ticks have no effect.

Test Plan:
- Reset and divider: hold clrn=0 for 10 clks, release. Required: hs=vs=1, rgb=0, x=0, y=0; pix_tick first high on clk 4, then every 4 clks.
- Line timing: count ticks across one line. Required: h_cnt wraps after 800 ticks; hs low for exactly 96 ticks, starting PIPE ticks after h_cnt=656.
- Frame timing: run one full frame. Required: v_cnt wraps after 525 lines; vs low for 2 lines (1600 ticks); exactly one frame_tick, at v_cnt=480, h_cnt=0.
- Colour alignment: drive color_in = 16'h0ABC when x=100, y=50, else 16'hF000. Required: with PIPE=1, {r,g,b}=12'hABC for exactly one tick, one tick after x=100; also repeat with PIPE=3.
- Blanking: drive color_in=16'hFFFF constantly. Required: rgb=12'hFFF only within the delayed active window, and 0 during every porch and sync interval.
- Mid-frame reset: assert clrn at v_cnt=200, h_cnt=300, between ticks. Required: all outputs go to reset values immediately (async); on release the counters restart at 0,0 and no spurious frame_tick occurs.
